// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the multi-channel keypad entry controller:
//   - key-index constants matching the scanned key vector of keypad_module
//   - debounce/action FSM state encoding
//   - BCD nibble width
//   - small helpers that classify a key code and decode its digit value
package keypad_pkg;

  localparam int BCD_W = 4;

  // Bit positions of each key in the scanned key vector
  localparam int KEY_D1      = 0;
  localparam int KEY_D2      = 1;
  localparam int KEY_D3      = 2;
  localparam int KEY_A       = 3;
  localparam int KEY_D4      = 4;
  localparam int KEY_D5      = 5;
  localparam int KEY_D6      = 6;
  localparam int KEY_B       = 7;
  localparam int KEY_D7      = 8;
  localparam int KEY_D8      = 9;
  localparam int KEY_D9      = 10;
  localparam int KEY_C       = 11;
  localparam int KEY_CONFIRM = 12;
  localparam int KEY_D0      = 13;
  localparam int KEY_ERASE   = 14;
  localparam int KEY_D       = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ACTION   = 2'd2,
    HELD     = 2'd3
  } key_state_e;

  // True when the key code is one of the ten digit keys
  function automatic logic is_digit_key(input int code);
    return (code == KEY_D0) || (code == KEY_D1) || (code == KEY_D2) ||
           (code == KEY_D3) || (code == KEY_D4) || (code == KEY_D5) ||
           (code == KEY_D6) || (code == KEY_D7) || (code == KEY_D8) ||
           (code == KEY_D9);
  endfunction

  // BCD value carried by a digit key; non-digit keys decode to 0
  function automatic logic [BCD_W-1:0] key_digit(input int code);
    logic [BCD_W-1:0] d;
    d = '0;
    case (code)
      KEY_D1:  d = 4'd1;
      KEY_D2:  d = 4'd2;
      KEY_D3:  d = 4'd3;
      KEY_D4:  d = 4'd4;
      KEY_D5:  d = 4'd5;
      KEY_D6:  d = 4'd6;
      KEY_D7:  d = 4'd7;
      KEY_D8:  d = 4'd8;
      KEY_D9:  d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer
// Clocked debounce of the scanned key vector. Accepts a press only after
// DEBOUNCE_SCANS consecutive identical one-hot scans, then emits a single
// action strobe and tracks the held key until DEBOUNCE_SCANS consecutive
// all-zero scans release it.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   keys           scanned key vector (one bit per key)
//   keys_valid     keys holds a complete scan this cycle
//   action_strobe  high for the single ACTION clock of an accepted press
//   key_code       index of the latched key
//   multi_err      one-cycle pulse when an idle scan has several keys down
//   key_held       debounced press state (HELD)
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int N_KEYS         = 16,
  parameter int DEBOUNCE_SCANS = 25,
  parameter int CODE_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys,
  input  logic              keys_valid,
  output logic              action_strobe,
  output logic [CODE_W-1:0] key_code,
  output logic              multi_err,
  output logic              key_held
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  key_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d;
  logic              one_hot;
  logic [CODE_W-1:0] hot_idx;

  // Classify the current scan: exactly one key down, and which one
  always_comb begin
    one_hot = (keys != '0) && ((keys & (keys - N_KEYS'(1))) == '0);
    hot_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (keys[i]) hot_idx = CODE_W'(i);
    end
  end

  // The same counter serves press debounce in DEBOUNCE and release debounce
  // in HELD; ACTION always lasts exactly one clock whatever keys_valid is.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (keys_valid) begin
          if (one_hot) begin
            code_d  = hot_idx;
            cnt_d   = CNT_W'(1);
            state_d = (DEBOUNCE_SCANS <= 1) ? ACTION : DEBOUNCE;
          end else if (keys != '0) begin
            err_d = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (keys_valid) begin
          if (one_hot && (hot_idx == code_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) state_d = ACTION;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      ACTION: begin
        cnt_d   = '0;
        state_d = HELD;
      end
      HELD: begin
        if (keys_valid) begin
          if (keys == '0) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign action_strobe = (state_q == ACTION);
  assign key_held      = (state_q == HELD);
  assign key_code      = code_q;
  assign multi_err     = err_q;

endmodule

// File: rtl/keypad_multi_entry_ctrl.sv
// keypad_multi_entry_ctrl
// Debounced keypad front end that edits an N_DIGITS BCD entry buffer and
// commits it into one of N_CHANNELS per-channel BCD registers.
// Optional feature macro: KEYPAD_AUTO_REPEAT_EN (held digit/erase keys
// re-execute every REPEAT_SCANS matching scans).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   keys         scanned key vector from keypad_module
//   keys_valid   keys is a complete scan this cycle
//   entry_bcd    edit buffer, nibble 0 least significant
//   digit_count  number of digits in the buffer
//   edit_chan    channel currently being edited
//   chan_bcd     committed values, channel k in slice k
//   chan_en      per-channel enables (toggled by A/B/C)
//   commit       pulse on confirm
//   next_page    pulse on key D
//   err          pulse on a rejected action or multi-key scan
//   key_held     debounced press state
module keypad_multi_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int N_COLUMN       = 4,
  parameter int N_ROW          = 4,
  parameter int N_DIGITS       = 7,
  parameter int N_CHANNELS     = 3,
  parameter int DEBOUNCE_SCANS = 25,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [N_COLUMN*N_ROW-1:0]                    keys,
  input  logic                                         keys_valid,
  output logic [4*N_DIGITS-1:0]                        entry_bcd,
  output logic [$clog2(N_DIGITS+1)-1:0]                digit_count,
  output logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] edit_chan,
  output logic [N_CHANNELS*4*N_DIGITS-1:0]             chan_bcd,
  output logic [N_CHANNELS-1:0]                        chan_en,
  output logic                                         commit,
  output logic                                         next_page,
  output logic                                         err,
  output logic                                         key_held
);

  localparam int N_KEYS  = N_COLUMN * N_ROW;
  localparam int CODE_W  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int DC_W    = $clog2(N_DIGITS + 1);
  localparam int CH_W    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int ENTRY_W = BCD_W * N_DIGITS;
  localparam logic [DC_W-1:0] DC_MAX  = DC_W'(N_DIGITS);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CHANNELS - 1);

  if (N_DIGITS < 1 || N_DIGITS > 15 || N_CHANNELS < 1 || N_CHANNELS > 8 ||
      DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1 || N_KEYS < 16) begin : g_bad_params
    $error("keypad_multi_entry_ctrl: parameter out of range");
  end

  logic              action_strobe, multi_err, rep_fire, exec;
  logic [CODE_W-1:0] key_code;

  key_debouncer #(
    .N_KEYS         (N_KEYS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .CODE_W         (CODE_W)
  ) u_debouncer (
    .clk           (clk),
    .rst_n         (rst_n),
    .keys          (keys),
    .keys_valid    (keys_valid),
    .action_strobe (action_strobe),
    .key_code      (key_code),
    .multi_err     (multi_err),
    .key_held      (key_held)
  );

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int               REP_W   = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);

  logic [REP_W-1:0] rep_q, rep_inc;
  logic             same_key;

  // A held key keeps counting matching scans; only digits and erase fire
  always_comb begin
    same_key = keys_valid && key_held && (keys == (N_KEYS'(1) << key_code));
    rep_inc  = rep_q + REP_W'(1);
    rep_fire = same_key && (rep_inc == REP_MAX) &&
               (is_digit_key(int'(key_code)) || (int'(key_code) == KEY_ERASE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else if (!key_held) begin
      rep_q <= '0;
    end else if (keys_valid) begin
      if (!same_key || (rep_inc == REP_MAX)) rep_q <= '0;
      else                                   rep_q <= rep_inc;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign exec = action_strobe | rep_fire;

  logic [ENTRY_W-1:0]                 entry_q, entry_d, load_v;
  logic [DC_W-1:0]                    count_q, count_d;
  logic [N_CHANNELS-1:0][ENTRY_W-1:0] chan_q, chan_d;
  logic [N_CHANNELS-1:0]              en_q, en_d;
  logic [CH_W-1:0]                    edit_q, edit_d, new_ch;
  logic                               commit_q, commit_d, next_q, next_d, err_q, err_d;
  int                                 code_i, en_idx;

  // Execute the latched key once per accepted press (or auto-repeat)
  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    chan_d   = chan_q;
    en_d     = en_q;
    edit_d   = edit_q;
    commit_d = 1'b0;
    next_d   = 1'b0;
    err_d    = 1'b0;
    load_v   = '0;
    new_ch   = '0;
    code_i   = int'(key_code);
    en_idx   = (code_i - KEY_A) / 4;
    if (exec) begin
      if (is_digit_key(code_i)) begin
        if (count_q < DC_MAX) begin
          entry_d = (entry_q << BCD_W) | ENTRY_W'(key_digit(code_i));
          count_d = count_q + DC_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (code_i == KEY_ERASE) begin
        if (count_q != '0) begin
          entry_d = entry_q >> BCD_W;
          count_d = count_q - DC_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (code_i == KEY_CONFIRM) begin
        for (int k = 0; k < N_CHANNELS; k++) begin
          if (CH_W'(k) == edit_q) chan_d[k] = entry_q;
        end
        commit_d = 1'b1;
      end else if ((code_i == KEY_A) || (code_i == KEY_B) || (code_i == KEY_C)) begin
        if (en_idx < N_CHANNELS) begin
          for (int k = 0; k < N_CHANNELS; k++) begin
            if (k == en_idx) en_d[k] = ~en_q[k];
          end
        end else begin
          err_d = 1'b1;
        end
      end else if (code_i == KEY_D) begin
        // Switching pages reloads the buffer from the new channel's
        // committed value; the digit count follows its highest nonzero digit
        new_ch = (edit_q == CH_LAST) ? '0 : edit_q + CH_W'(1);
        for (int k = 0; k < N_CHANNELS; k++) begin
          if (CH_W'(k) == new_ch) load_v = chan_q[k];
        end
        edit_d  = new_ch;
        entry_d = load_v;
        count_d = '0;
        for (int n = 0; n < N_DIGITS; n++) begin
          if (load_v[n*BCD_W +: BCD_W] != '0) count_d = DC_W'(n + 1);
        end
        next_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q  <= '0;
      count_q  <= '0;
      chan_q   <= '0;
      en_q     <= '0;
      edit_q   <= '0;
      commit_q <= 1'b0;
      next_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      count_q  <= count_d;
      chan_q   <= chan_d;
      en_q     <= en_d;
      edit_q   <= edit_d;
      commit_q <= commit_d;
      next_q   <= next_d;
      err_q    <= err_d;
    end
  end

  assign entry_bcd   = entry_q;
  assign digit_count = count_q;
  assign edit_chan   = edit_q;
  assign chan_bcd    = chan_q;
  assign chan_en     = en_q;
  assign commit      = commit_q;
  assign next_page   = next_q;
  assign err         = err_q | multi_err;

endmodule

// File: tb/tb_keypad_multi_entry_ctrl.sv
// tb_keypad_multi_entry_ctrl
// Self-checking bench: a queue-based behavioural model of the keypad entry
// rules is compared against the DUT on every falling edge, and directed
// key sequences pin absolute values with hand-computed literals.
module tb_keypad_multi_entry_ctrl;

  localparam int ND  = 7;
  localparam int NCH = 2;
  localparam int DEB = 4;
  localparam int REP = 8;
  localparam int EW  = 4 * ND;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     keys = '0;
  logic            keys_valid = 1'b0;
  logic [EW-1:0]   entry_bcd;
  logic [2:0]      digit_count;
  logic [0:0]      edit_chan;
  logic [NCH*EW-1:0] chan_bcd;
  logic [NCH-1:0]  chan_en;
  logic            commit, next_page, err, key_held;

  keypad_multi_entry_ctrl #(
    .N_COLUMN       (4),
    .N_ROW          (4),
    .N_DIGITS       (ND),
    .N_CHANNELS     (NCH),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys        (keys),
    .keys_valid  (keys_valid),
    .entry_bcd   (entry_bcd),
    .digit_count (digit_count),
    .edit_chan   (edit_chan),
    .chan_bcd    (chan_bcd),
    .chan_en     (chan_en),
    .commit      (commit),
    .next_page   (next_page),
    .err         (err),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_commit = 0, n_next = 0, n_err = 0;
  bit checking = 1'b0;

  // Key positions by meaning; digit value per key bit (-1 = not a digit)
  localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 4, K5 = 5, K6 = 6, K7 = 8,
                 K8 = 9, K9 = 10, K0 = 13, KA = 3, KB = 7, KC = 11,
                 KD = 15, KCONF = 12, KERASE = 14;
  int digit_of [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};

  // ---------------- behavioural model ----------------
  int              m_q[$];            // entered digits, m_q[0] = newest
  logic [EW-1:0]   m_chan [NCH];
  logic [NCH-1:0]  m_en = '0;
  int              m_edit = 0;
  bit              m_held = 0, m_pend = 0;
  int              m_code = 0, m_run = 0, m_rel = 0, m_rep = 0;
  bit              e_commit = 0, e_next = 0, e_err = 0;
  int              s_pc, s_idx, s_top;

  function automatic logic [63:0] entry_of();
    logic [63:0] v;
    v = '0;
    foreach (m_q[i]) v[i*4 +: 4] = 4'(m_q[i]);
    return v;
  endfunction

  function automatic logic [63:0] chan_of();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*EW +: EW] = m_chan[k];
    return v;
  endfunction

  task automatic model_action(input int c);
    int ch;
    ch = (c - KA) / 4;
    if (digit_of[c] >= 0) begin
      if (m_q.size() < ND) m_q.push_front(digit_of[c]);
      else e_err = 1;
    end else if (c == KERASE) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else e_err = 1;
    end else if (c == KCONF) begin
      m_chan[m_edit] = entry_of()[EW-1:0];
      e_commit = 1;
    end else if (c == KA || c == KB || c == KC) begin
      if (ch < NCH) m_en[ch] = ~m_en[ch];
      else e_err = 1;
    end else if (c == KD) begin
      m_edit = (m_edit + 1) % NCH;
      e_next = 1;
      m_q.delete();
      s_top = -1;
      for (int i = 0; i < ND; i++) if (m_chan[m_edit][i*4 +: 4] != 4'd0) s_top = i;
      for (int i = 0; i <= s_top; i++) m_q.push_back(int'(m_chan[m_edit][i*4 +: 4]));
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      for (int k = 0; k < NCH; k++) m_chan[k] = '0;
      m_en = '0; m_edit = 0; m_held = 0; m_pend = 0;
      m_code = 0; m_run = 0; m_rel = 0; m_rep = 0;
      e_commit = 0; e_next = 0; e_err = 0;
    end else begin
      e_commit = 0; e_next = 0; e_err = 0;
      s_pc = $countones(keys);
      s_idx = 0;
      for (int i = 0; i < 16; i++) if (keys[i]) s_idx = i;
      if (m_pend) begin
        m_pend = 0;
        model_action(m_code);
        m_held = 1; m_rel = 0; m_rep = 0;
      end else if (keys_valid) begin
        if (!m_held) begin
          if (m_run > 0) begin
            if (s_pc == 1 && s_idx == m_code) m_run++;
            else m_run = 0;
          end else if (s_pc == 1) begin
            m_code = s_idx; m_run = 1;
          end else if (s_pc > 1) begin
            e_err = 1;
          end
          if (m_run == DEB) begin m_pend = 1; m_run = 0; end
        end else if (s_pc == 0) begin
          m_rep = 0;
          m_rel++;
          if (m_rel == DEB) begin m_held = 0; m_rel = 0; end
        end else begin
          m_rel = 0;
          if (s_pc == 1 && s_idx == m_code) begin
            m_rep++;
            if (m_rep == REP) begin
              m_rep = 0;
`ifdef KEYPAD_AUTO_REPEAT_EN
              if (digit_of[m_code] >= 0 || m_code == KERASE) model_action(m_code);
`endif
            end
          end else begin
            m_rep = 0;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc_entry",  64'(entry_bcd),   entry_of());
      checkOutput("cyc_count",  64'(digit_count), 64'(m_q.size()));
      checkOutput("cyc_edit",   64'(edit_chan),   64'(m_edit));
      checkOutput("cyc_chan",   64'(chan_bcd),    chan_of());
      checkOutput("cyc_en",     64'(chan_en),     64'(m_en));
      checkOutput("cyc_commit", 64'(commit),      64'(e_commit));
      checkOutput("cyc_next",   64'(next_page),   64'(e_next));
      checkOutput("cyc_err",    64'(err),         64'(e_err));
      checkOutput("cyc_held",   64'(key_held),    64'(m_held));
      if (commit)    n_commit++;
      if (next_page) n_next++;
      if (err)       n_err++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] kb(input int idx);
    logic [15:0] v;
    v = 16'h0001;
    return v << idx;
  endfunction

  task automatic scan(input logic [15:0] k);
    @(negedge clk);
    keys = k;
    keys_valid = 1'b1;
    @(negedge clk);
    keys_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int hold);
    repeat (hold) scan(k);
    repeat (DEB) scan(16'h0000);
  endtask

  int err0, com0, nxt0;

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    checkOutput("reset_entry", 64'(entry_bcd), 64'h0);
    checkOutput("reset_count", 64'(digit_count), 64'h0);
    checkOutput("reset_held",  64'(key_held), 64'h0);

    // Digit entry 1,2,3
    applyStimulus(kb(K1), DEB);
    applyStimulus(kb(K2), DEB);
    applyStimulus(kb(K3), DEB);
    checkOutput("digits_entry", 64'(entry_bcd), 64'h0000123);
    checkOutput("digits_count", 64'(digit_count), 64'd3);

    // Bounce: 3-scan burst ignored, then a proper press of 5
    repeat (3) scan(kb(K5));
    scan(16'h0000);
    applyStimulus(kb(K5), DEB);
    checkOutput("bounce_entry", 64'(entry_bcd), 64'h0001235);

    // Fill the buffer and overflow it
    applyStimulus(kb(K6), DEB);
    applyStimulus(kb(K7), DEB);
    applyStimulus(kb(K8), DEB);
    err0 = n_err;
    applyStimulus(kb(K9), DEB);
    checkOutput("full_entry", 64'(entry_bcd), 64'h1235678);
    checkOutput("full_count", 64'(digit_count), 64'd7);
    checkOutput("full_err",   64'(n_err - err0), 64'd1);

    // Erase past empty
    err0 = n_err;
    repeat (8) applyStimulus(kb(KERASE), DEB);
    checkOutput("erase_count", 64'(digit_count), 64'd0);
    checkOutput("erase_entry", 64'(entry_bcd), 64'h0);
    checkOutput("erase_err",   64'(n_err - err0), 64'd1);

    // Commit 440 then page through channels
    applyStimulus(kb(K4), DEB);
    applyStimulus(kb(K4), DEB);
    applyStimulus(kb(K0), DEB);
    com0 = n_commit;
    applyStimulus(kb(KCONF), DEB);
    checkOutput("commit_chan0", 64'(chan_bcd[EW-1:0]), 64'h440);
    checkOutput("commit_pulse", 64'(n_commit - com0), 64'd1);
    nxt0 = n_next;
    applyStimulus(kb(KD), DEB);
    checkOutput("page1_edit",  64'(edit_chan), 64'd1);
    checkOutput("page1_entry", 64'(entry_bcd), 64'h0);
    checkOutput("page1_pulse", 64'(n_next - nxt0), 64'd1);
    applyStimulus(kb(KD), DEB);
    checkOutput("page0_edit",  64'(edit_chan), 64'd0);
    checkOutput("page0_entry", 64'(entry_bcd), 64'h440);
    checkOutput("page0_count", 64'(digit_count), 64'd3);

    // Channel enables: C is out of range for two channels
    err0 = n_err;
    applyStimulus(kb(KC), DEB);
    checkOutput("enC_err", 64'(n_err - err0), 64'd1);
    checkOutput("enC_en",  64'(chan_en), 64'h0);
    applyStimulus(kb(KA), DEB);
    checkOutput("enA_en",  64'(chan_en), 64'h1);
    applyStimulus(kb(KB), DEB);
    checkOutput("enB_en",  64'(chan_en), 64'h3);

    // Two keys at once
    err0 = n_err;
    applyStimulus(kb(K1) | kb(K2), 1);
    checkOutput("multi_err",   64'(n_err - err0), 64'd1);
    checkOutput("multi_count", 64'(digit_count), 64'd3);

    // Asynchronous reset in the middle of a debounce
    scan(kb(K5));
    scan(kb(K5));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_entry", 64'(entry_bcd), 64'h0);
    checkOutput("arst_chan",  64'(chan_bcd), 64'h0);
    checkOutput("arst_en",    64'(chan_en), 64'h0);
    checkOutput("arst_count", 64'(digit_count), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * DEB) scan(16'h0000);
    checkOutput("arst_noact_count", 64'(digit_count), 64'd0);
    checkOutput("arst_noact_held",  64'(key_held), 64'd0);

    // Long hold of 7
    applyStimulus(kb(K7), DEB + 20);
`ifdef KEYPAD_AUTO_REPEAT_EN
    checkOutput("hold7_count", 64'(digit_count), 64'd3);
    checkOutput("hold7_entry", 64'(entry_bcd), 64'h777);
`else
    checkOutput("hold7_count", 64'(digit_count), 64'd1);
    checkOutput("hold7_entry", 64'(entry_bcd), 64'h7);
`endif

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_multi_entry_ctrl.md
Name: keypad_multi_entry_ctrl

Overview:
Parametrised successor to the single-channel keypad frequency-entry controller. Consumes the scanned key vector from keypad_module and debounces it with a clocked counter, replacing the combinational debounce. Edits an N_DIGITS BCD entry buffer and commits it into one of N_CHANNELS per-channel BCD registers, which feed the BCD-to-C2 and DDFS converters. Adds channel selection, channel enables, an error flag, and optional key auto-repeat.

Parameters:
N_COLUMN, 4, keypad columns
N_ROW, 4, keypad rows
N_DIGITS, 7, BCD digits per entry (1..15)
N_CHANNELS, 3, independently committed frequency channels (1..8)
DEBOUNCE_SCANS, 25, consecutive identical valid scans required to accept a press or a release
REPEAT_SCANS, 250, held-key scans between auto-repeats (AUTO_REPEAT_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
keys  in  N_COLUMN*N_ROW  one bit per key from keypad_module out_keys
keys_valid  in  1  keys is a complete scan sample this cycle
entry_bcd  out  4*N_DIGITS  edit buffer; nibble 0 is the least-significant digit
digit_count  out  $clog2(N_DIGITS+1)  digits entered
edit_chan  out  max(1,$clog2(N_CHANNELS))  channel being edited
chan_bcd  out  N_CHANNELS*4*N_DIGITS  committed values; channel k occupies slice k
chan_en  out  N_CHANNELS  per-channel output enable
commit  out  1  one-cycle pulse on confirm
next_page  out  1  one-cycle pulse on key D
err  out  1  one-cycle pulse on a rejected action
key_held  out  1  debounced press state

Behaviour:
- Reset (async, rst_n=0): all outputs are 0, the FSM goes to IDLE, and all counters are cleared. Reset mid-debounce or mid-hold discards the press; no action fires after release of reset.
- Key map (bit index): digits 1,2,3 = 0,1,2; 4,5,6 = 4,5,6; 7,8,9 = 8,9,10; 0 = 13. A/B/C = 3/7/11. D = 15. Confirm = 12. Erase = 14.
- The FSM advances only on cycles with keys_valid=1. On all other cycles state, counters and outputs hold, and the pulse outputs are 0.
- IDLE: a one-hot nonzero sample latches the code, sets cnt=1 and moves to DEBOUNCE. An all-zero sample stays in IDLE. A multi-hot sample stays in IDLE and pulses err.
- DEBOUNCE: a sample equal to the latched code increments cnt. When cnt reaches DEBOUNCE_SCANS, go to ACTION. Any other sample returns to IDLE with cnt=0.
- ACTION: lasts exactly one clock, independent of keys_valid. Executes the latched key, then goes to HELD with key_held=1. Registered outputs update on this clock edge, so an action lands exactly DEBOUNCE_SCANS valid samples after the first matching sample.
- HELD: an all-zero sample increments the release counter. Any nonzero sample clears it. When the counter reaches DEBOUNCE_SCANS, go to IDLE with key_held=0. Exactly one action fires per press.
- Digit key: if digit_count<N_DIGITS, shift entry_bcd up one nibble, insert the digit at nibble 0, and increment digit_count. At N_DIGITS the buffer is unchanged and err pulses. A leading 0 counts as a digit.
- Erase: if digit_count>0, shift entry_bcd down one nibble, zero the top nibble, and decrement. At 0 nothing changes and err pulses.
- Confirm: copy entry_bcd into chan_bcd[edit_chan] and pulse commit. The buffer and digit_count are retained.
- A/B/C: toggle chan_en[0/1/2]. If the index is ≥N_CHANNELS, pulse err and change nothing.
- D: edit_chan advances by 1, wrapping from N_CHANNELS-1 to 0, and next_page pulses. The entry buffer is loaded from chan_bcd of the new channel. digit_count becomes the index of the highest nonzero nibble plus 1, or 0 if all nibbles are zero. An uncommitted edit is discarded.
- The only simultaneous event is an action together with a new sample; the sample is ignored in ACTION.

Optional Feature:
- Macro: KEYPAD_AUTO_REPEAT_EN.
- Defined: while in HELD with the same key held, a repeat counter counts matching samples. Each time it reaches REPEAT_SCANS it re-executes the action and resets. Repeat applies to digit and erase keys only; confirm, A/B/C and D never repeat.
- Undefined: there is no repeat logic and no repeat counter. REPEAT_SCANS is unused.

Decomposition:
- Package keypad_pkg holds:
  - key-index localparams: KEY_D0..KEY_D9, KEY_A, KEY_B, KEY_C, KEY_D, KEY_CONFIRM, KEY_ERASE;
  - FSM state encoding: IDLE, DEBOUNCE, ACTION, HELD;
  - the BCD nibble width constant.
- One sub-module, key_debouncer, covers IDLE/DEBOUNCE/HELD, the counters and one-hot checking. Its outputs are action_strobe, key_code and multi_err. The parent holds the buffer, channel logic and repeat logic.

Test Plan:
- Digit entry: DEBOUNCE_SCANS=4, N_DIGITS=7; press 1,2,3 (each held 4 scans, released 4) → entry_bcd=0x0000123, digit_count=3, one action per press.
- Bounce: key 5 for 3 scans, then 0, then 5 for 4 → exactly one '5' inserted; the 3-scan burst is ignored.
- Buffer limits: enter 8 digits → 8th rejected with a 1-cycle err, count=7. Erase 8 times → count=0, buffer 0, err on the 8th.
- Commit and channel switch: enter 440, confirm → chan_bcd[0]=0x440, commit pulse. Press D → edit_chan=1, entry_bcd=0, next_page pulse. Press D twice → edit_chan=0, entry_bcd=0x440, digit_count=3.
- Channel enables and errors: N_CHANNELS=2; press C → err, chan_en unchanged. Press A → chan_en=2'b01. Press keys 1 and 2 together → err, no digit entered.
- Async reset and auto-repeat: assert rst_n low mid-debounce, asynchronously between clock edges → all outputs 0 immediately and no late action after release. With KEYPAD_AUTO_REPEAT_EN and REPEAT_SCANS=8, hold '7' for 4+20 scans → 3 digits '7' entered; without the macro, 1.
